accum_mc: RTL and testbench

- Parametrised multi-channel signed/unsigned accumulator; next generation of the single-channel 8-bit add/sub accumulator.
- Holds CH independent N-bit accumulators, each with carry and sticky overflow flags.
- Accepts one op per cycle through a valid/ready handshake and posts a registered result.
- Supports a multi-cycle clear-all sweep; sits between switch/key input logic and the hex/LED display decoders.

---
 rtl/accum_pkg.sv | 49 ++++
 rtl/accum_alu.sv | 34 +++
 rtl/accum_mc.sv | 101 ++++++++++
 tb/tb_accum_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - op codes, FSM state type and shared add/sub arithmetic for accum_mc
package accum_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int MAX_W = 64;

  typedef enum logic {IDLE, SWEEP} state_t;

  // Operands are zero-extended to MAX_W; w is the live width. Returns {carry, ovf, result}.
  function automatic logic [MAX_W+1:0] alu_calc(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic [1:0]       op,
                                                input logic [6:0]       w);
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] smask;
    logic [MAX_W-1:0] mask;
    logic             carry;
    logic             ovf;
    logic             sa;
    logic             sb;
    logic             sr;
    smask = MAX_W'(1) << (w - 7'd1);
    mask  = smask | (smask - MAX_W'(1));
    sa    = |(a & smask);
    sb    = |(b & smask);
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD:  full = {1'b0, a} + {1'b0, b};
      OP_SUB:  full = {1'b0, a} - {1'b0, b};
      OP_LOAD: full = {1'b0, b};
      default: full = '0;
    endcase
    sr = |(full[MAX_W-1:0] & smask);
    if (op == OP_ADD)
      ovf = (sa == sb) && (sr != sa);
    else if (op == OP_SUB)
      ovf = (sa != sb) && (sr != sa);
    // Bit w of the widened value is the carry out (or borrow for SUB).
    if (op == OP_ADD || op == OP_SUB)
      carry = |(full & ({1'b0, smask} << 1));
    return {carry, ovf, full[MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/accum_alu.sv
// rtl/accum_alu.sv - combinational accumulator ALU; ACCUM_SAT_EN clamps on signed overflow
module accum_alu
  import accum_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_acc,
  input  logic [N-1:0] i_data,
  input  logic [1:0]   i_op,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_ovf
);

  logic [MAX_W+1:0] w_calc;
  logic             w_unused;

  assign w_calc   = alu_calc(MAX_W'(i_acc), MAX_W'(i_data), i_op, 7'(N));
  assign o_carry  = w_calc[MAX_W+1];
  assign o_ovf    = w_calc[MAX_W];
  assign w_unused = &{1'b0, w_calc[MAX_W-1:N]};

`ifdef ACCUM_SAT_EN
  // Overflow direction follows the sign of the old accumulator.
  always_comb begin
    o_result = w_calc[N-1:0];
    if (w_calc[MAX_W] && (i_op == OP_ADD || i_op == OP_SUB))
      o_result = i_acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign o_result = w_calc[N-1:0];
`endif

endmodule

// File: rtl/accum_mc.sv
// rtl/accum_mc.sv - CH-channel N-bit accumulator with handshake and clear-all sweep (option: ACCUM_SAT_EN)
module accum_mc
  import accum_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int CH = 4,
  localparam int CW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [1:0]    in_op,
  input  logic [N-1:0]  in_data,
  input  logic          clr_all,
  output logic          res_valid,
  output logic [CW-1:0] res_ch,
  output logic [N-1:0]  res_data,
  output logic          res_carry,
  output logic          res_ovf,
  input  logic [CW-1:0] rd_ch,
  output logic [N-1:0]  rd_data,
  output logic          rd_ovf
);

  logic [N-1:0]  r_acc [CH];
  logic [CH-1:0] r_ovf;
  state_t        r_state;
  logic [CW-1:0] r_idx;
  logic          r_ready;

  logic [N-1:0]  w_alu_res;
  logic          w_alu_carry;
  logic          w_alu_ovf;
  logic          w_ovf_new;
  logic          w_accept;
  logic          w_arith;

  accum_alu #(.N(N)) u_alu (
    .i_acc    (r_acc[in_ch]),
    .i_data   (in_data),
    .i_op     (in_op),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry),
    .o_ovf    (w_alu_ovf)
  );

  assign w_arith   = (in_op == OP_ADD) || (in_op == OP_SUB);
  assign w_ovf_new = w_arith ? (r_ovf[in_ch] | w_alu_ovf) : 1'b0;
  assign w_accept  = in_valid & r_ready & ~clr_all;
  assign in_ready  = r_ready;
  assign rd_data   = r_acc[rd_ch];
  assign rd_ovf    = r_ovf[rd_ch];

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_ovf     <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      for (int i = 0; i < CH; i++) r_acc[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (clr_all) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_ready <= 1'b0;
          end else if (w_accept) begin
            r_acc[in_ch] <= w_alu_res;
            r_ovf[in_ch] <= w_ovf_new;
            res_valid    <= 1'b1;
            res_ch       <= in_ch;
            res_data     <= w_alu_res;
            res_carry    <= w_alu_carry;
            res_ovf      <= w_ovf_new;
          end
        end
        SWEEP: begin
          r_acc[r_idx] <= '0;
          r_ovf[r_idx] <= 1'b0;
          r_idx        <= r_idx + CW'(1);
          if (r_idx == CW'(CH - 1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_mc.sv
// tb/tb_accum_mc.sv - directed self-checking bench for accum_mc (N=8, CH=4)
module tb_accum_mc;

  logic       clk;
  logic       aclr;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic       clr_all;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_ovf;
  logic [1:0] rd_ch;
  logic [7:0] rd_data;
  logic       rd_ovf;

  int n_pass;
  int n_total;

  accum_mc dut (
    .clk       (clk),
    .aclr      (aclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_op     (in_op),
    .in_data   (in_data),
    .clr_all   (clr_all),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data),
    .rd_ovf    (rd_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and clock it in; in_valid stays high so calls chain back to back.
  task automatic issue(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d);
    in_valid = 1'b1;
    in_ch    = ch;
    in_op    = op;
    in_data  = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    aclr = 1'b0;
    #2;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++;
    if ({res_valid, res_ch, res_data, res_carry, res_ovf} !== 13'h0)
      $display("FAIL reset_res got %h want 0", {res_valid, res_ch, res_data, res_carry, res_ovf});
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      rd_ch = c[1:0];
      #1;
      n_total++;
      if ({rd_data, rd_ovf} !== 9'h0)
        $display("FAIL reset_rd ch%0d got %h/%b want 00/0", c, rd_data, rd_ovf);
      else n_pass++;
    end
    tick();
    aclr = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] e1;
    logic [7:0] e2;
`ifdef ACCUM_SAT_EN
    e1 = 8'h7F;
    e2 = 8'h7F;
`else
    e1 = 8'h80;
    e2 = 8'h81;
`endif
    issue(2'd1, 2'b10, 8'h7F);
    n_total++;
    if (res_valid !== 1'b1 || res_data !== 8'h7F || res_ovf !== 1'b0)
      $display("FAIL ovf_load got v=%b d=%h o=%b want 1/7f/0", res_valid, res_data, res_ovf);
    else n_pass++;
    issue(2'd1, 2'b00, 8'h01);
    n_total++;
    if (res_ch !== 2'd1 || res_data !== e1 || res_carry !== 1'b0 || res_ovf !== 1'b1)
      $display("FAIL ovf_add1 got ch=%0d d=%h c=%b o=%b want 1/%h/0/1", res_ch, res_data, res_carry, res_ovf, e1);
    else n_pass++;
    issue(2'd1, 2'b00, 8'h01);
    idle();
    n_total++;
    if (res_data !== e2 || res_carry !== 1'b0 || res_ovf !== 1'b1)
      $display("FAIL ovf_add2 got d=%h c=%b o=%b want %h/0/1", res_data, res_carry, res_ovf, e2);
    else n_pass++;
    rd_ch = 2'd1;
    #1;
    n_total++;
    if (rd_data !== e2 || rd_ovf !== 1'b1)
      $display("FAIL ovf_rd got %h/%b want %h/1", rd_data, rd_ovf, e2);
    else n_pass++;
  endtask

  task automatic test_sub();
    issue(2'd0, 2'b10, 8'h05);
    issue(2'd0, 2'b01, 8'h07);
    idle();
    n_total++;
    if (res_ch !== 2'd0 || res_data !== 8'hFE || res_carry !== 1'b1 || res_ovf !== 1'b0)
      $display("FAIL sub_borrow got ch=%0d d=%h c=%b o=%b want 0/fe/1/0", res_ch, res_data, res_carry, res_ovf);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(2'd2, 2'b00, 8'hFF);
    n_total++;
    if (res_valid !== 1'b1 || res_data !== 8'hFF || res_carry !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_first got v=%b d=%h c=%b r=%b want 1/ff/0/1", res_valid, res_data, res_carry, in_ready);
    else n_pass++;
    issue(2'd2, 2'b00, 8'h01);
    idle();
    n_total++;
    if (res_valid !== 1'b1 || res_data !== 8'h00 || res_carry !== 1'b1 || res_ovf !== 1'b0)
      $display("FAIL b2b_second got v=%b d=%h c=%b o=%b want 1/00/1/0", res_valid, res_data, res_carry, res_ovf);
    else n_pass++;
    tick();
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL b2b_strobe_drop got %b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_clr_all();
    int low_cnt;
    int res_cnt;
    issue(2'd0, 2'b10, 8'h11);
    issue(2'd1, 2'b10, 8'h22);
    issue(2'd2, 2'b10, 8'h33);
    issue(2'd3, 2'b10, 8'h44);
    in_ch   = 2'd0;
    in_op   = 2'b00;
    in_data = 8'h01;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    idle();
    low_cnt = 0;
    res_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (in_ready === 1'b0) low_cnt++;
      if (res_valid === 1'b1) res_cnt++;
      tick();
    end
    n_total++;
    if (low_cnt !== 4) $display("FAIL clr_ready_low got %0d cycles want 4", low_cnt); else n_pass++;
    n_total++;
    if (res_cnt !== 0) $display("FAIL clr_no_result got %0d strobes want 0", res_cnt); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      rd_ch = c[1:0];
      #1;
      n_total++;
      if (rd_data !== 8'h00 || rd_ovf !== 1'b0)
        $display("FAIL clr_rd ch%0d got %h/%b want 00/0", c, rd_data, rd_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    issue(2'd1, 2'b10, 8'h55);
    idle();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    tick();
    aclr = 1'b0;
    #1;
    n_total++;
    if ({in_ready, res_valid, res_ch, res_data, res_carry, res_ovf} !== 14'h0)
      $display("FAIL midsweep_outputs got %h want 0", {in_ready, res_valid, res_ch, res_data, res_carry, res_ovf});
    else n_pass++;
    rd_ch = 2'd1;
    #1;
    n_total++;
    if (rd_data !== 8'h00) $display("FAIL midsweep_rd got %h want 00", rd_data); else n_pass++;
    tick();
    aclr = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL midsweep_ready got %b want 1", in_ready); else n_pass++;
    issue(2'd0, 2'b10, 8'h12);
    idle();
    n_total++;
    if (res_valid !== 1'b1 || res_data !== 8'h12)
      $display("FAIL midsweep_op got v=%b d=%h want 1/12", res_valid, res_data);
    else n_pass++;
  endtask

  task automatic test_sticky();
    logic [7:0] exp_d [4];
    logic [3:0] exp_c;
    logic [3:0] exp_o;
`ifdef ACCUM_SAT_EN
    exp_d = '{8'h40, 8'h7F, 8'h7F, 8'h7F};
    exp_c = 4'b0000;
`else
    exp_d = '{8'h40, 8'h80, 8'hC0, 8'h00};
    exp_c = 4'b1000;
`endif
    exp_o = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      issue(2'd3, 2'b00, 8'h40);
      n_total++;
      if (res_valid !== 1'b1 || res_data !== exp_d[k] || res_carry !== exp_c[k] || res_ovf !== exp_o[k])
        $display("FAIL sticky_add%0d got v=%b d=%h c=%b o=%b want 1/%h/%b/%b",
                 k, res_valid, res_data, res_carry, res_ovf, exp_d[k], exp_c[k], exp_o[k]);
      else n_pass++;
    end
    issue(2'd3, 2'b11, 8'hAA);
    idle();
    n_total++;
    if (res_data !== 8'h00 || res_carry !== 1'b0 || res_ovf !== 1'b0)
      $display("FAIL sticky_clear got d=%h c=%b o=%b want 00/0/0", res_data, res_carry, res_ovf);
    else n_pass++;
    rd_ch = 2'd3;
    #1;
    n_total++;
    if (rd_ovf !== 1'b0) $display("FAIL sticky_clear_rd got %b want 0", rd_ovf); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    in_valid = 1'b0;
    in_ch    = 2'd0;
    in_op    = 2'b00;
    in_data  = 8'h00;
    clr_all  = 1'b0;
    rd_ch    = 2'd0;
    test_reset();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_clr_all();
    test_reset_mid_sweep();
    test_sticky();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
